// File: rtl/hpu_regif_axil_master_if.sv
// AXI4-lite bus bundle between the HPU register-interface master and a register bank.
// The master modport drives the address, data, valid and response-ready signals.
interface hpu_regif_axil_master_if #(
  parameter int ADD_W  = 32,
  parameter int DATA_W = 32
);
  logic [ADD_W-1:0]  awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADD_W-1:0]  araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/hpu_regif_axil_master.sv
// Single-outstanding AXI4-lite initiator used by on-chip sequencers to reach the
// HPU register banks; one request in, one response out, with a saturating error count.
module hpu_regif_axil_master #(
  parameter int AXIL_ADD_W  = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   i_cfg_clk,
  input  logic                   i_cfg_srst_n,
  input  logic                   i_req_vld,
  output logic                   o_req_rdy,
  input  logic                   i_req_wr,
  input  logic [AXIL_ADD_W-1:0]  i_req_addr,
  input  logic [AXIL_DATA_W-1:0] i_req_wdata,
  output logic                   o_rsp_vld,
  input  logic                   i_rsp_rdy,
  output logic                   o_rsp_wr,
  output logic [AXIL_DATA_W-1:0] o_rsp_rdata,
  output logic [1:0]             o_rsp_resp,
  output logic [ERR_CNT_W-1:0]   o_err_cnt,
  input  logic                   i_err_cnt_clr,
  hpu_regif_axil_master_if.master m_axil
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_req_rdy;
  logic                   r_wr;
  logic [AXIL_ADD_W-1:0]  r_addr;
  logic [AXIL_DATA_W-1:0] r_wdata;
  logic                   r_awvalid;
  logic                   r_wvalid;
  logic                   r_arvalid;
  logic [AXIL_DATA_W-1:0] r_rsp_rdata;
  logic [1:0]             r_rsp_resp;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic       w_req_hs;
  logic       w_aw_done;
  logic       w_w_done;
  logic       w_b_hs;
  logic       w_r_hs;
  logic       w_cap;
  logic [1:0] w_cap_resp;

  // r_req_rdy is only ever high in IDLE, so it alone qualifies acceptance.
  assign w_req_hs   = i_req_vld & r_req_rdy;
  assign w_aw_done  = ~r_awvalid | m_axil.awready;
  assign w_w_done   = ~r_wvalid  | m_axil.wready;
  assign w_b_hs     = (r_state == WR_RESP) & m_axil.bvalid;
  assign w_r_hs     = (r_state == RD_RESP) & m_axil.rvalid;
  assign w_cap      = w_b_hs | w_r_hs;
  assign w_cap_resp = w_b_hs ? m_axil.bresp : m_axil.rresp;

  always_ff @(posedge i_cfg_clk or negedge i_cfg_srst_n) begin
    if (!i_cfg_srst_n) r_state <= IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_state_nxt = i_req_wr ? WR_REQ : RD_REQ;
      WR_REQ:  if (w_aw_done && w_w_done) w_state_nxt = WR_RESP;
      WR_RESP: if (m_axil.bvalid) w_state_nxt = RSP;
      RD_REQ:  if (m_axil.arready) w_state_nxt = RD_RESP;
      RD_RESP: if (m_axil.rvalid) w_state_nxt = RSP;
      RSP:     if (i_rsp_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_cfg_clk or negedge i_cfg_srst_n) begin
    if (!i_cfg_srst_n) begin
      r_req_rdy   <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      r_req_rdy <= (w_state_nxt == IDLE);
      if (w_req_hs) begin
        r_wr      <= i_req_wr;
        r_addr    <= {i_req_addr[AXIL_ADD_W-1:2], 2'b00};
        r_wdata   <= i_req_wdata;
        r_awvalid <= i_req_wr;
        r_wvalid  <= i_req_wr;
        r_arvalid <= ~i_req_wr;
      end else begin
        // AW and W retire independently; each valid drops on its own handshake.
        if (r_awvalid && m_axil.awready) r_awvalid <= 1'b0;
        if (r_wvalid  && m_axil.wready)  r_wvalid  <= 1'b0;
        if (r_arvalid && m_axil.arready) r_arvalid <= 1'b0;
      end
      if (w_b_hs) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_axil.bresp;
      end
      if (w_r_hs) begin
        r_rsp_rdata <= m_axil.rdata;
        r_rsp_resp  <= m_axil.rresp;
      end
    end
  end

  // Clear wins over a same-cycle error so software sees a clean zero.
  always_ff @(posedge i_cfg_clk or negedge i_cfg_srst_n) begin
    if (!i_cfg_srst_n)                                  r_err_cnt <= '0;
    else if (i_err_cnt_clr)                             r_err_cnt <= '0;
    else if (w_cap && (w_cap_resp != 2'b00) && (r_err_cnt != '1))
                                                        r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign o_req_rdy   = r_req_rdy;
  assign o_rsp_vld   = (r_state == RSP);
  assign o_rsp_wr    = r_wr;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_err_cnt   = r_err_cnt;

  assign m_axil.awaddr  = r_addr;
  assign m_axil.awvalid = r_awvalid;
  assign m_axil.wdata   = r_wdata;
  assign m_axil.wvalid  = r_wvalid;
  assign m_axil.bready  = (r_state == WR_RESP);
  assign m_axil.araddr  = r_addr;
  assign m_axil.arvalid = r_arvalid;
  assign m_axil.rready  = (r_state == RD_RESP);

endmodule

// File: doc/hpu_regif_axil_master.md
# hpu_regif_axil_master

AXI4-lite initiator that issues single register accesses into the HPU register banks on the cfg_clk domain. A simple valid/ready request port accepts one read or write command at a time; the block drives the full AXI4-lite master channel set and returns the read data and response on a valid/ready response port. It is used by on-chip sequencers (boot-time BSK address programming, reset-trigger writes) that need to reach the register banks without a host.

## Interface
- AXIL_ADD_W, axi_if_shell_axil_pkg::AXIL_ADD_W: address width.
- AXIL_DATA_W, axi_if_shell_axil_pkg::AXIL_DATA_W: data width (32).
- ERR_CNT_W, 16: width of saturating error counter.
- cfg_clk  in  1  clock; one clock, all logic on rising edge.
- cfg_srst_n  in  1  reset, asynchronous, active-low.
- req_vld / req_rdy  in / out  1  request handshake.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  AXIL_ADD_W  byte address.
- req_wdata  in  AXIL_DATA_W  write data (ignored for reads).
- rsp_vld / rsp_rdy  out / in  1  response handshake.
- rsp_wr  out  1  echo of req_wr.
- rsp_rdata  out  AXIL_DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP captured.
- err_cnt  out  ERR_CNT_W  count of non-OKAY responses, saturating.
- err_cnt_clr  in  1  synchronous clear of err_cnt.
- m_axil_awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-lite master channels, widths per parameters, directions mirrored from a slave.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: req_rdy=1. On req_vld: latch wr/addr/wdata; addr[1:0] forced to 0 on the bus; go WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid asserted together; each deasserts independently on its own handshake (AW and W may complete in any order or the same cycle). Leave when both done → WR_RESP.
- WR_RESP: bready=1; on bvalid capture bresp → RSP.
- RD_REQ: arvalid=1 until arready → RD_RESP.
- RD_RESP: rready=1; on rvalid capture rdata, rresp → RSP.
- RSP: rsp_vld=1, outputs stable until rsp_rdy → IDLE.
- Exactly one outstanding transaction; bready/rready only asserted in their wait states.
- err_cnt increments by 1 when a captured resp != 2'b00 on entry to RSP; saturates at all-ones; err_cnt_clr has priority over increment in the same cycle.
- Valid signals never depend combinationally on ready (all *valid registered).

## Timing
- Reset values: req_rdy=0 during reset, 1 on first cycle after release; all *valid, bready, rready, rsp_vld=0; addresses, data, rsp_* and err_cnt=0.
- Request accepted at cycle 0 → awvalid/wvalid (or arvalid) high at cycle 1.
- Zero-wait slave: write: AW/W handshake cycle 1, bready cycle 2, bvalid at 2 → rsp_vld cycle 3. Read: AR cycle 1, R cycle 2, rsp_vld cycle 3.
- rsp_rdy at cycle 3 → req_rdy high cycle 4; minimum 4 cycles per access.
- Reset asserted mid-transaction: all outputs forced to reset values immediately; transaction abandoned (slave is reset in the same domain); no response emitted.
- Backpressure on rsp: FSM stays in RSP indefinitely; no new request accepted.

## Test plan
- Write 0x1234_5678 to 0x0000_0010, zero-wait slave -> awaddr=0x10, wdata=0x12345678 at cycle 1; rsp_vld cycle 3, rsp_resp=0, rsp_wr=1, err_cnt=0.
- Read 0x0000_0014, slave returns 0xCAFE_F00D after 5-cycle rvalid delay -> rready held high throughout, rsp_rdata=0xCAFEF00D, rsp_resp=0.
- Write with wready 3 cycles before awready, then reversed order -> each valid drops on its own handshake; exactly one AW and one W beat; single response.
- Slave returns SLVERR on three accesses, err_cnt_clr pulsed with a fourth error arriving same cycle -> err_cnt 1,2,3 then 0; with ERR_CNT_W=2, five errors -> saturates at 3.
- Unaligned req_addr 0x0000_0023 -> bus address 0x0000_0020.
- Assert cfg_srst_n low while in WR_RESP -> awvalid/wvalid/bready/rsp_vld=0 immediately; after release req_rdy=1, no stale rsp_vld.
